// File: rtl/wb_write_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : wb_arb_pkg
// Brief  : Shared types and constants for the write-port arbiter.
// Rev    : 1.0  initial release
// ============================================================================
package wb_arb_pkg;

  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned WB_ADDR_W = 5;

  // Register 0 is hard-wired; writes to it are dropped.
  localparam int unsigned REG_ZERO = 0;

  typedef enum logic [1:0] {
    GNT_NONE  = 2'd0,
    GNT_PIPE  = 2'd1,
    GNT_QUEUE = 2'd2
  } grant_e;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/wb_write_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : wb_write_port_arbiter_if
// Brief  : WB-stage, long-latency unit, hazard-check and register-file bus
//          around the write-port arbiter.
// Rev    : 1.0  initial release
// ============================================================================
interface wb_write_port_arbiter_if #(
  parameter int INST_SZ     = 32,
  parameter int REG_ADDR_SZ = 5
);
  logic                   i_reg_write_W;
  logic [REG_ADDR_SZ-1:0] i_waddr_W;
  logic [INST_SZ-1:0]     i_wdata_W;
  logic                   o_stall_W;
  logic                   i_lu_valid;
  logic [REG_ADDR_SZ-1:0] i_lu_addr;
  logic [INST_SZ-1:0]     i_lu_data;
  logic                   o_lu_ready;
  logic [REG_ADDR_SZ-1:0] i_chk_rs;
  logic [REG_ADDR_SZ-1:0] i_chk_rt;
  logic                   o_q_hazard;
  logic                   o_rf_we;
  logic [REG_ADDR_SZ-1:0] o_rf_waddr;
  logic [INST_SZ-1:0]     o_rf_wdata;

  // Surrounding pipeline / environment side.
  modport master (
    output i_reg_write_W, i_waddr_W, i_wdata_W,
    output i_lu_valid, i_lu_addr, i_lu_data,
    output i_chk_rs, i_chk_rt,
    input  o_stall_W, o_lu_ready, o_q_hazard,
    input  o_rf_we, o_rf_waddr, o_rf_wdata
  );

  // Arbiter side.
  modport slave (
    input  i_reg_write_W, i_waddr_W, i_wdata_W,
    input  i_lu_valid, i_lu_addr, i_lu_data,
    input  i_chk_rs, i_chk_rt,
    output o_stall_W, o_lu_ready, o_q_hazard,
    output o_rf_we, o_rf_waddr, o_rf_wdata
  );
endinterface
`default_nettype wire

// File: rtl/wb_write_port_arbiter_result_fifo.sv
`default_nettype none
// ============================================================================
// Module : wb_result_fifo
// Brief  : Small circular FIFO of pending long-latency register writes, with
//          per-entry valid/address taps for dependency compares.
// Rev    : 1.0  initial release
// ============================================================================
module wb_result_fifo #(
  parameter int DEPTH = 2,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  wire logic                     i_clk,
  input  wire logic                     i_rst_n,
  input  wire logic                     i_push,
  input  wire logic [AW-1:0]            i_push_addr,
  input  wire logic [DW-1:0]            i_push_data,
  input  wire logic                     i_pop,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [AW-1:0]                 o_head_addr,
  output logic [DW-1:0]                 o_head_data,
  output logic [DEPTH-1:0]              o_ent_valid,
  output logic [DEPTH-1:0][AW-1:0]      o_ent_addr
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  entry_t [DEPTH-1:0] mem_q;
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  // Pointer, count and valid-bit next state; pointers wrap at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    valid_d  = valid_q;
    count_d  = count_q;
    if (i_pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    if (i_push) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    case ({i_push, i_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register; reset discards every pending entry.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      valid_q  <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      valid_q  <= valid_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful while the valid bit is set.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mem_q <= '0;
    end else if (i_push) begin
      mem_q[wr_ptr_q] <= '{addr: i_push_addr, data: i_push_data};
    end
  end

  assign o_full      = (count_q == CNT_W'(DEPTH));
  assign o_empty     = (count_q == '0);
  assign o_head_addr = mem_q[rd_ptr_q].addr;
  assign o_head_data = mem_q[rd_ptr_q].data;
  assign o_ent_valid = valid_q;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
      assign o_ent_addr[gi] = mem_q[gi].addr;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/wb_write_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : wb_write_port_arbiter
// Brief  : Shares the register-file write port between the WB stage and a
//          queue of long-latency results; starvation and WAW force the queue.
// Rev    : 1.0  initial release
// ============================================================================
module wb_write_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int INST_SZ     = WB_DATA_W,
  parameter int REG_ADDR_SZ = WB_ADDR_W,
  parameter int Q_DEPTH     = 2,
  parameter int STARVE_MAX  = 4
) (
  input  wire logic             i_clk,
  input  wire logic             i_rst_n,
  wb_write_port_arbiter_if.slave bus
);

  localparam int SC_W = $clog2(STARVE_MAX + 1);
  localparam logic [REG_ADDR_SZ-1:0] ADDR_ZERO = REG_ADDR_SZ'(REG_ZERO);
  localparam logic [SC_W-1:0]        SC_MAX    = SC_W'(STARVE_MAX);

  logic                             fifo_full, fifo_empty, lu_push, q_pop;
  logic [REG_ADDR_SZ-1:0]           head_addr;
  logic [INST_SZ-1:0]               head_data;
  logic [Q_DEPTH-1:0]               ent_valid;
  logic [Q_DEPTH-1:0][REG_ADDR_SZ-1:0] ent_addr;

  logic                   pipe_req, waw_hit, hazard, force_queue;
  grant_e                 grant;
  logic [SC_W-1:0]        starve_cnt_q, starve_cnt_d;
  logic                   rf_we_q, rf_we_d;
  logic [REG_ADDR_SZ-1:0] rf_waddr_q, rf_waddr_d;
  logic [INST_SZ-1:0]     rf_wdata_q, rf_wdata_d;

  assign pipe_req = bus.i_reg_write_W & (bus.i_waddr_W != ADDR_ZERO);
  assign lu_push  = bus.i_lu_valid & ~fifo_full & (bus.i_lu_addr != ADDR_ZERO);
  assign q_pop    = (grant == GNT_QUEUE);

  wb_result_fifo #(
    .DEPTH (Q_DEPTH),
    .AW    (REG_ADDR_SZ),
    .DW    (INST_SZ)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (lu_push),
    .i_push_addr (bus.i_lu_addr),
    .i_push_data (bus.i_lu_data),
    .i_pop       (q_pop),
    .o_full      (fifo_full),
    .o_empty     (fifo_empty),
    .o_head_addr (head_addr),
    .o_head_data (head_data),
    .o_ent_valid (ent_valid),
    .o_ent_addr  (ent_addr)
  );

  // Compare every pending entry against the WB destination and decode sources.
  always_comb begin
    waw_hit = 1'b0;
    hazard  = 1'b0;
    for (int i = 0; i < Q_DEPTH; i++) begin
      if (ent_valid[i]) begin
        if (ent_addr[i] == bus.i_waddr_W) waw_hit = 1'b1;
        if ((ent_addr[i] != ADDR_ZERO) &&
            ((ent_addr[i] == bus.i_chk_rs) || (ent_addr[i] == bus.i_chk_rt)))
          hazard = 1'b1;
      end
    end
  end

  // Single grant per cycle: pipe by default, queue when forced or pipe idle.
  always_comb begin
    force_queue = ~fifo_empty & ((starve_cnt_q == SC_MAX) | waw_hit);
    grant       = GNT_NONE;
    if (pipe_req && !force_queue) grant = GNT_PIPE;
    else if (!fifo_empty)         grant = GNT_QUEUE;
  end

  // Starvation counter and registered write-port next state.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (fifo_empty || grant == GNT_QUEUE) starve_cnt_d = '0;
    else if (starve_cnt_q != SC_MAX)      starve_cnt_d = starve_cnt_q + SC_W'(1);
    rf_we_d    = (grant != GNT_NONE);
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    case (grant)
      GNT_PIPE: begin
        rf_waddr_d = bus.i_waddr_W;
        rf_wdata_d = bus.i_wdata_W;
      end
      GNT_QUEUE: begin
        rf_waddr_d = head_addr;
        rf_wdata_d = head_data;
      end
      default: ;
    endcase
  end

  // Write-port output register and starvation state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      starve_cnt_q <= '0;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
    end
  end

  assign bus.o_stall_W  = pipe_req & force_queue;
  assign bus.o_lu_ready = ~fifo_full;
  assign bus.o_q_hazard = hazard;
  assign bus.o_rf_we    = rf_we_q;
  assign bus.o_rf_waddr = rf_waddr_q;
  assign bus.o_rf_wdata = rf_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_write_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_wb_write_port_arbiter
// Brief  : Directed scoreboard bench for the register-file write-port arbiter.
// Rev    : 1.0  initial release
// ============================================================================
module tb_wb_write_port_arbiter;
  import wb_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;
  wb_req_t exp_q[$];

  // Starvation scenario: destination sequence (r5 repeats while held) and
  // the stall expected in each cycle.
  logic [4:0] t4_addr  [7] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd5, 5'd6};
  logic       t4_stall [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  wb_write_port_arbiter_if #(.INST_SZ(32), .REG_ADDR_SZ(5)) bus ();

  wb_write_port_arbiter #(
    .INST_SZ     (32),
    .REG_ADDR_SZ (5),
    .Q_DEPTH     (2),
    .STARVE_MAX  (4)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back('{addr: a, data: d});
  endtask

  task automatic idle_inputs();
    bus.i_reg_write_W = 1'b0;
    bus.i_waddr_W     = '0;
    bus.i_wdata_W     = '0;
    bus.i_lu_valid    = 1'b0;
    bus.i_lu_addr     = '0;
    bus.i_lu_data     = '0;
  endtask

  // Monitor: every register-file write must match the next expected write.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.o_rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                 bus.o_rf_waddr, bus.o_rf_wdata);
      end else begin
        wb_req_t e;
        e = exp_q.pop_front();
        chk("rf_waddr", 32'(bus.o_rf_waddr), 32'(e.addr));
        chk("rf_wdata", bus.o_rf_wdata, e.data);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    bus.i_chk_rs = '0;
    bus.i_chk_rt = '0;

    // 1. Reset values
    step();
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rf_we",    32'(bus.o_rf_we), 32'd0);
    chk("rst_rf_waddr", 32'(bus.o_rf_waddr), 32'd0);
    chk("rst_rf_wdata", bus.o_rf_wdata, 32'd0);
    chk("rst_lu_ready", 32'(bus.o_lu_ready), 32'd1);
    chk("rst_stall",    32'(bus.o_stall_W), 32'd0);
    chk("rst_hazard",   32'(bus.o_q_hazard), 32'd0);

    // 2. Plain pipe write, empty FIFO
    step();
    bus.i_reg_write_W = 1'b1;
    bus.i_waddr_W     = 5'd5;
    bus.i_wdata_W     = 32'hDEADBEEF;
    expect_wr(5'd5, 32'hDEADBEEF);
    @(negedge clk);
    chk("t2_stall", 32'(bus.o_stall_W), 32'd0);
    step();
    idle_inputs();

    // 3. Register-0 requests from both sources are dropped
    bus.i_reg_write_W = 1'b1;
    bus.i_lu_valid    = 1'b1;
    bus.i_lu_data     = 32'h1;
    @(negedge clk);
    chk("t3_stall", 32'(bus.o_stall_W), 32'd0);
    chk("t3_ready", 32'(bus.o_lu_ready), 32'd1);
    step();
    idle_inputs();
    @(negedge clk);
    chk("t3_ready_after", 32'(bus.o_lu_ready), 32'd1);

    // 4. Starvation: r7 queued, pipe busy; queue forced on the 5th cycle
    step();
    bus.i_lu_valid = 1'b1;
    bus.i_lu_addr  = 5'd7;
    bus.i_lu_data  = 32'h11;
    bus.i_chk_rs   = 5'd7;
    expect_wr(5'd1, 32'h101);
    expect_wr(5'd2, 32'h102);
    expect_wr(5'd3, 32'h103);
    expect_wr(5'd4, 32'h104);
    expect_wr(5'd7, 32'h11);
    expect_wr(5'd5, 32'h105);
    expect_wr(5'd6, 32'h106);
    @(negedge clk);
    chk("t4_ready", 32'(bus.o_lu_ready), 32'd1);
    chk("t4_hazard_pre", 32'(bus.o_q_hazard), 32'd0);
    for (int k = 0; k < 7; k++) begin
      step();
      bus.i_lu_valid    = 1'b0;
      bus.i_reg_write_W = 1'b1;
      bus.i_waddr_W     = t4_addr[k];
      bus.i_wdata_W     = 32'h100 + 32'(t4_addr[k]);
      @(negedge clk);
      chk("t4_stall",  32'(bus.o_stall_W), 32'(t4_stall[k]));
      chk("t4_hazard", 32'(bus.o_q_hazard), (k < 5) ? 32'd1 : 32'd0);
    end
    step();
    idle_inputs();

    // 5. WAW: queued r9=AA must be written before the pipe's r9=BB
    bus.i_lu_valid = 1'b1;
    bus.i_lu_addr  = 5'd9;
    bus.i_lu_data  = 32'hAA;
    bus.i_chk_rs   = 5'd9;
    expect_wr(5'd9, 32'hAA);
    expect_wr(5'd9, 32'hBB);
    @(negedge clk);
    chk("t5_hazard_pre", 32'(bus.o_q_hazard), 32'd0);
    step();
    bus.i_lu_valid    = 1'b0;
    bus.i_reg_write_W = 1'b1;
    bus.i_waddr_W     = 5'd9;
    bus.i_wdata_W     = 32'hBB;
    @(negedge clk);
    chk("t5_stall",  32'(bus.o_stall_W), 32'd1);
    chk("t5_hazard", 32'(bus.o_q_hazard), 32'd1);
    step();
    @(negedge clk);
    chk("t5_stall_held",  32'(bus.o_stall_W), 32'd0);
    chk("t5_hazard_done", 32'(bus.o_q_hazard), 32'd0);
    step();
    idle_inputs();

    // 6. Fill the FIFO while the pipe is busy, then reset mid-sequence
    bus.i_chk_rs      = 5'd11;
    bus.i_reg_write_W = 1'b1;
    bus.i_waddr_W     = 5'd10;
    bus.i_wdata_W     = 32'hA10;
    bus.i_lu_valid    = 1'b1;
    bus.i_lu_addr     = 5'd11;
    bus.i_lu_data     = 32'hB11;
    expect_wr(5'd10, 32'hA10);
    expect_wr(5'd12, 32'hA12);
    @(negedge clk);
    chk("t6_ready0", 32'(bus.o_lu_ready), 32'd1);
    step();
    bus.i_waddr_W = 5'd12;
    bus.i_wdata_W = 32'hA12;
    bus.i_lu_addr = 5'd13;
    bus.i_lu_data = 32'hB13;
    @(negedge clk);
    chk("t6_ready1",  32'(bus.o_lu_ready), 32'd1);
    chk("t6_hazard1", 32'(bus.o_q_hazard), 32'd1);
    step();
    bus.i_waddr_W = 5'd14;
    bus.i_wdata_W = 32'hA14;
    bus.i_lu_addr = 5'd15;
    bus.i_lu_data = 32'hB15;
    @(negedge clk);
    chk("t6_ready_full", 32'(bus.o_lu_ready), 32'd0);
    chk("t6_stall",      32'(bus.o_stall_W), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_rf_we",  32'(bus.o_rf_we), 32'd0);
    chk("t6_rst_ready",  32'(bus.o_lu_ready), 32'd1);
    chk("t6_rst_hazard", 32'(bus.o_q_hazard), 32'd0);
    step();
    idle_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_post_ready",  32'(bus.o_lu_ready), 32'd1);
    chk("t6_post_hazard", 32'(bus.o_q_hazard), 32'd0);
    repeat (4) step();
    @(negedge clk);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
